// File: rtl/call_stack_if.sv
// Handshake bundle between the IF-stage control unit and the return-address stack.
// The controller drives push/pop/flush/clear_err; the stack drives the data and status outputs.
interface call_stack_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              push;
   logic              pop;
   logic              flush;
   logic              clear_err;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] pop_data;
   logic              pop_valid;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              overflow;
   logic              underflow;

   modport master (
      output push, pop, flush, clear_err, push_data,
      input  pop_data, pop_valid, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, flush, clear_err, push_data,
      output pop_data, pop_valid, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/call_stack.sv
// LIFO return-address stack driven on CALL (push) and RET (pop).
// Storage is a circular buffer indexed by ptr_q, so overwrite-when-full needs no data movement.
module call_stack #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 8,
   parameter bit          WRAP   = 1'b0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   call_stack_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d, top_idx, waddr;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] pop_data_q, pop_data_d;
   logic              pop_valid_q, pop_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              we, ovf_set, unf_set, is_empty, is_full;

   // DEPTH is a power of two, so PTR_W-bit arithmetic wraps modulo DEPTH for free.
   assign top_idx  = ptr_q - PTR_W'(1);
   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CntMax);

   always_comb begin
      ptr_d       = ptr_q;
      count_d     = count_q;
      pop_data_d  = pop_data_q;
      pop_valid_d = 1'b0;
      we          = 1'b0;
      waddr       = ptr_q;
      ovf_set     = 1'b0;
      unf_set     = 1'b0;

      if (bus.flush) begin
         ptr_d   = '0;
         count_d = '0;
      end else if (bus.push && bus.pop) begin
         pop_valid_d = 1'b1;
         if (is_empty) begin
            pop_data_d = bus.push_data;
         end else begin
            // Replace top: read the old value and overwrite the same slot in one cycle.
            pop_data_d = mem_q[top_idx];
            we         = 1'b1;
            waddr      = top_idx;
         end
      end else if (bus.pop) begin
         if (is_empty) begin
            unf_set = 1'b1;
         end else begin
            pop_data_d  = mem_q[top_idx];
            pop_valid_d = 1'b1;
            ptr_d       = top_idx;
            count_d     = count_q - CNT_W'(1);
         end
      end else if (bus.push) begin
         if (!is_full) begin
            we      = 1'b1;
            ptr_d   = ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(1);
         end else begin
            ovf_set = 1'b1;
            if (WRAP) begin
               we    = 1'b1;
               ptr_d = ptr_q + PTR_W'(1);
            end
         end
      end

      // A new error in the same cycle as clear_err wins.
      overflow_d  = ovf_set | (overflow_q & ~bus.clear_err);
      underflow_d = unf_set | (underflow_q & ~bus.clear_err);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q       <= '0;
         count_q     <= '0;
         pop_data_q  <= '0;
         pop_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         count_q     <= count_d;
         pop_data_q  <= pop_data_d;
         pop_valid_q <= pop_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we && !rst_i) begin
         mem_q[waddr] <= bus.push_data;
      end
   end

   assign bus.pop_data  = pop_data_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.count     = count_q;
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: one drop-on-full and one wrap-on-full instance share stimulus.
module tb_call_stack;
   logic        clk = 1'b0;
   logic        rst;
   logic        push, pop, flush, clear_err;
   logic [31:0] push_data;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   call_stack_if #(.DATA_W(32), .DEPTH(8)) b0 ();
   call_stack_if #(.DATA_W(32), .DEPTH(8)) b1 ();

   assign b0.push = push;   assign b1.push = push;
   assign b0.pop = pop;     assign b1.pop = pop;
   assign b0.flush = flush; assign b1.flush = flush;
   assign b0.clear_err = clear_err;  assign b1.clear_err = clear_err;
   assign b0.push_data = push_data;  assign b1.push_data = push_data;

   call_stack #(.DATA_W(32), .DEPTH(8), .WRAP(1'b0)) u_drop (.clk_i(clk), .rst_i(rst), .bus(b0));
   call_stack #(.DATA_W(32), .DEPTH(8), .WRAP(1'b1)) u_wrap (.clk_i(clk), .rst_i(rst), .bus(b1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of stimulus, then sample 1 time unit after the edge.
   task automatic cyc(input logic ph, input logic pp, input logic fl, input logic ce,
                      input logic [31:0] d);
      push = ph; pop = pp; flush = fl; clear_err = ce; push_data = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; push_data = '0;
   endtask

   initial begin
      rst = 1'b1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; push_data = '0;
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      rst = 1'b0;
      chk("rst_count", 32'(b0.count), 0);
      chk("rst_empty", 32'(b0.empty), 1);
      chk("rst_full", 32'(b0.full), 0);
      chk("rst_valid", 32'(b0.pop_valid), 0);
      chk("rst_data", b0.pop_data, 0);
      chk("rst_ovf", 32'(b0.overflow), 0);
      chk("rst_unf", 32'(b0.underflow), 0);

      // Basic LIFO order
      cyc(1, 0, 0, 0, 32'h100);
      cyc(1, 0, 0, 0, 32'h104);
      cyc(1, 0, 0, 0, 32'h108);
      chk("t1_count3", 32'(b0.count), 3);
      cyc(0, 1, 0, 0, 0);
      chk("t1_pop0_data", b0.pop_data, 32'h108);
      chk("t1_pop0_valid", 32'(b0.pop_valid), 1);
      cyc(0, 1, 0, 0, 0);
      chk("t1_pop1_data", b0.pop_data, 32'h104);
      cyc(0, 1, 0, 0, 0);
      chk("t1_pop2_data", b0.pop_data, 32'h100);
      chk("t1_pop2_valid", 32'(b0.pop_valid), 1);
      chk("t1_count0", 32'(b0.count), 0);
      chk("t1_empty", 32'(b0.empty), 1);
      cyc(0, 0, 0, 0, 0);
      chk("t1_idle_valid", 32'(b0.pop_valid), 0);

      // Full behaviour: drop (u_drop) versus overwrite oldest (u_wrap)
      for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 32'(i));
      chk("t2_full", 32'(b0.full), 1);
      chk("t2_count8", 32'(b0.count), 8);
      chk("t2_ovf_pre", 32'(b0.overflow), 0);
      cyc(1, 0, 0, 0, 32'd9);
      chk("t2_ovf", 32'(b0.overflow), 1);
      chk("t2_count_drop", 32'(b0.count), 8);
      chk("t3_ovf", 32'(b1.overflow), 1);
      cyc(1, 0, 0, 0, 32'd10);
      chk("t3_count", 32'(b1.count), 8);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 1, 0, 0, 0);
         chk($sformatf("t2_pop%0d", i), b0.pop_data, 32'(8 - i));
         chk($sformatf("t3_pop%0d", i), b1.pop_data, 32'(10 - i));
      end
      chk("t3_empty", 32'(b1.empty), 1);
      chk("t2_unf_pre", 32'(b0.underflow), 0);
      cyc(0, 1, 0, 0, 0);
      chk("t2_unf", 32'(b0.underflow), 1);
      chk("t2_unf_valid", 32'(b0.pop_valid), 0);
      chk("t2_unf_data", b0.pop_data, 32'd1);

      // Sticky flags and clear_err
      cyc(0, 0, 0, 1, 0);
      chk("t4_clr_unf", 32'(b0.underflow), 0);
      chk("t4_clr_ovf", 32'(b0.overflow), 0);
      cyc(0, 1, 0, 0, 0);
      chk("t4_unf", 32'(b0.underflow), 1);
      chk("t4_valid", 32'(b0.pop_valid), 0);
      chk("t4_count", 32'(b0.count), 0);
      cyc(0, 0, 0, 0, 0);
      chk("t4_sticky", 32'(b0.underflow), 1);
      cyc(0, 0, 0, 1, 0);
      chk("t4_clr", 32'(b0.underflow), 0);
      cyc(0, 1, 0, 1, 0);
      chk("t4_set_wins", 32'(b0.underflow), 1);
      cyc(0, 0, 0, 1, 0);

      // Push+pop replace-top and empty bypass
      cyc(1, 0, 0, 0, 32'h10);
      cyc(1, 0, 0, 0, 32'h20);
      cyc(1, 1, 0, 0, 32'h30);
      chk("t5_rep_data", b0.pop_data, 32'h20);
      chk("t5_rep_valid", 32'(b0.pop_valid), 1);
      chk("t5_rep_count", 32'(b0.count), 2);
      cyc(0, 1, 0, 0, 0);
      chk("t5_after_rep", b0.pop_data, 32'h30);
      cyc(0, 1, 0, 0, 0);
      chk("t5_bottom", b0.pop_data, 32'h10);
      cyc(1, 1, 0, 0, 32'h44);
      chk("t5_byp_data", b0.pop_data, 32'h44);
      chk("t5_byp_valid", 32'(b0.pop_valid), 1);
      chk("t5_byp_count", 32'(b0.count), 0);
      chk("t5_byp_unf", 32'(b0.underflow), 0);

      // Flush beats push; flags survive flush; reset beats push
      cyc(0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 32'h200 + 32'(i));
      chk("t6_count5", 32'(b0.count), 5);
      cyc(1, 0, 1, 0, 32'h300);
      chk("t6_flush_count", 32'(b0.count), 0);
      chk("t6_flush_empty", 32'(b0.empty), 1);
      chk("t6_flush_unf", 32'(b0.underflow), 1);
      chk("t6_flush_data", b0.pop_data, 32'h44);
      cyc(1, 0, 0, 0, 32'h400);
      cyc(0, 1, 0, 0, 0);
      chk("t6_post_flush", b0.pop_data, 32'h400);
      rst = 1'b1;
      cyc(1, 0, 0, 0, 32'h500);
      rst = 1'b0;
      chk("t6_rst_count", 32'(b0.count), 0);
      chk("t6_rst_data", b0.pop_data, 0);
      chk("t6_rst_valid", 32'(b0.pop_valid), 0);
      chk("t6_rst_unf", 32'(b0.underflow), 0);
      chk("t6_rst_ovf", 32'(b1.overflow), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
